mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (requester I) and the data cache (requester D) on a block-level read/write handshake.
- Sits below both caches and above the data memory model; together with the pipeline busywait chain, it is the only path to memory.
- Grants one transaction at a time, round-robin on contention.
- Latches the address and data of the winning request, forwards the memory completion back to the winner only, and holds the loser in busywait.

Parameters:
- ADDR_W, 28, block address width (word address bits above the block offset)
- DATA_W, 128, block data width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- i_read  input  1  I-cache block read request (level, held until its busywait is low)
- i_address  input  ADDR_W  I-cache block address
- i_readdata  output  DATA_W  block returned to the I-cache
- i_busywait  output  1  I-cache stall
- d_read  input  1  D-cache block read request
- d_write  input  1  D-cache block write-back request
- d_address  input  ADDR_W  D-cache block address
- d_writedata  input  DATA_W  D-cache write-back block
- d_readdata  output  DATA_W  block returned to the D-cache
- d_busywait  output  1  D-cache stall
- mem_read  output  1  memory read strobe (registered)
- mem_write  output  1  memory write strobe (registered)
- mem_address  output  ADDR_W  latched block address (registered)
- mem_writedata  output  DATA_W  latched write data (registered)
- mem_readdata  input  DATA_W  memory read data, valid in the completion cycle
- mem_busywait  input  1  memory busy; low while a strobe is high marks the completion cycle

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; mem_read, mem_write, mem_address and mem_writedata all 0; last_grant=I.
  - On release, the D-cache wins the first contention.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one requester pending: grant it.
  - Both pending: grant the requester other than last_grant.
  - At the grant edge: latch address (and d_writedata for a write), set mem_read or mem_write, update last_grant, go to BUSY_x.
  - Request-to-strobe latency is 1 cycle.
- d_read and d_write both high: treated as a write.
- BUSY_x:
  - Strobe and latched fields are held constant while mem_busywait==1.
  - A cycle with mem_busywait==0 is the completion cycle. In it, x_busywait is driven 0 and x_readdata = mem_readdata, both combinationally.
  - At the end of the completion cycle: strobes cleared, go to IDLE.
  - Minimum transaction is 2 cycles (grant + completion).
- Busywait:
  - x_busywait = (x has read/write high) AND NOT (state==BUSY_x AND mem_busywait==0).
  - A requester with no request sees busywait 0.
  - The non-granted requester stays busy for the whole foreign transaction.
- Readdata: x_readdata is 0 outside x's completion cycle.
- Request changes while granted: address/data/type changes are ignored because the fields are latched.
  - If a request drops mid-transaction, the memory transaction still completes and its result is discarded.
  - No abort path.
- Back-to-back: one IDLE cycle separates transactions. A requester still pending after completion (new request) competes normally in that IDLE cycle.
- Starvation bound: with both requesters permanently requesting, grants strictly alternate.
- Reset mid-transaction:
  - Immediate return to IDLE, strobes low.
  - The memory model is reset by the same signal.

Decomposition:
- Shared package: arb_state_t enum (IDLE, BUSY_I, BUSY_D), requester ID constants REQ_I=0 and REQ_D=1, default widths.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin pick from (req_i, req_d, last_grant).
- The FSM, latches and muxes stay in the top.

Test Plan:
- I-read alone at addr 0x0000010, memory busy 4 cycles, readdata 0xA5A5…: mem_read rises 1 cycle after the request; i_busywait low only in the completion cycle; i_readdata=0xA5A5…; d_busywait stays 0.
- D-write alone at addr 0x0000020, data 0x1234…: mem_write=1 with mem_address=0x0000020 and mem_writedata=0x1234…, held stable until completion, then 0.
- I and D request in the same cycle right after reset: D is granted first. I is granted in the IDLE cycle after D completes, and i_busywait stays 1 until then.
- Both requesters held high for 4 transactions: grant order D, I, D, I; each completion routes readdata only to its owner.
- During a BUSY_I transaction, change i_address from 0x10 to 0x99: mem_address stays 0x10 until completion.
- Pull reset to 0 mid-BUSY_D: mem_write and mem_read drop asynchronously, state is IDLE, and after release an I-only request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   DEFAULT_ADDR_W / DEFAULT_DATA_W - default block address and block data widths
//   arb_state_t                     - arbiter FSM states
//   REQ_I / REQ_D                   - requester IDs used for grants and last_grant
package mem_port_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 28;
  localparam int DEFAULT_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick between the I-cache and the D-cache.
// Ports:
//   req_i, req_d - pending requests from each requester
//   last_grant   - ID of the requester granted most recently
//   grant_valid  - at least one requester is pending
//   grant_id     - ID of the requester to grant (meaningful when grant_valid)
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = REQ_I;
    if (req_i && req_d) begin
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory block port between the I-cache and the D-cache.
// One transaction at a time, round-robin on contention. The winning request's
// address, type and write data are latched onto registered memory strobes;
// the completion (mem_busywait low while a strobe is up) is routed only to
// the owner, while any other pending requester stays in busywait.
// Ports:
//   clk, reset                        - clock, asynchronous active-low reset
//   i_read, i_address                 - I-cache block read request
//   i_readdata, i_busywait            - I-cache response / stall
//   d_read, d_write, d_address,
//   d_writedata                       - D-cache block read / write-back request
//   d_readdata, d_busywait            - D-cache response / stall
//   mem_read, mem_write, mem_address,
//   mem_writedata                     - registered memory request
//   mem_readdata, mem_busywait        - memory response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;

  logic req_i, req_d;
  logic grant_valid, grant_id;
  logic i_done, d_done;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  rr_pick2 u_pick (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Grants happen only from IDLE, so a finished transaction always leaves
  // one IDLE cycle in which both requesters compete again. A D request with
  // both read and write high is a write-back.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_id;
          if (grant_id == REQ_D) begin
            state_d       = BUSY_D;
            mem_address_d = d_address;
            mem_write_d   = d_write;
            mem_read_d    = ~d_write;
            if (d_write) begin
              mem_writedata_d = d_writedata;
            end
          end else begin
            state_d       = BUSY_I;
            mem_address_d = i_address;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (!mem_busywait) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // last_grant resets to I so that the D-cache wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      last_grant_q    <= REQ_I;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  // Completion is released combinationally so the owner can leave its stall
  // in the same cycle the memory finishes.
  assign i_done = (state_q == BUSY_I) && !mem_busywait;
  assign d_done = (state_q == BUSY_D) && !mem_busywait;

  assign i_busywait = req_i && !i_done;
  assign d_busywait = req_d && !d_done;

  assign i_readdata = i_done ? mem_readdata : '0;
  assign d_readdata = d_done ? mem_readdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and memory.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] A5   = {4{32'hA5A5A5A5}};
  localparam logic [DW-1:0] JUNK = {4{32'hDEADBEEF}};
  localparam logic [DW-1:0] WD   = {8{16'h1234}};

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  int errors = 0;
  int checks = 0;

  // Memory model: stays busy for mem_lat cycles after a strobe rises.
  int            mem_cnt;
  int            mem_lat = 0;
  logic [DW-1:0] mem_arr [0:255];
  logic [DW-1:0] ref_mem [0:255];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [7:0] idx);
    return {4{24'hC0FFEE, idx}};
  endfunction

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < mem_lat);
  assign mem_readdata = (mem_read && !mem_busywait) ? mem_arr[mem_address[7:0]] : JUNK;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cnt <= 0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 16) ? A5 : pat(8'(i));
    end else if (mem_read || mem_write) begin
      if (!mem_busywait) begin
        mem_cnt <= 0;
        if (mem_write) mem_arr[mem_address[7:0]] <= mem_writedata;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_read = 0; d_read = 0; d_write = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    i_read = 1; i_address = 28'h0000055;
    repeat (2) @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (mem_address !== '0) begin errors++; $display("[TB] FAIL reset_mem_address: got %h want 0", mem_address); end
    checks++; if (mem_writedata !== '0) begin errors++; $display("[TB] FAIL reset_mem_writedata: got %h want 0", mem_writedata); end
    checks++; if (i_busywait !== 1'b1) begin errors++; $display("[TB] FAIL reset_i_busywait: got %b want 1", i_busywait); end
    checks++; if (d_busywait !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_busywait: got %b want 0", d_busywait); end
    checks++; if (i_readdata !== '0) begin errors++; $display("[TB] FAIL reset_i_readdata: got %h want 0", i_readdata); end
    i_read = 0;
    reset = 1'b1;
  endtask

  task automatic test_i_read();
    mem_lat = 4;
    tick();
    i_read = 1; i_address = 28'h0000010;
    sample();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL iread_latency: got %b want 0", mem_read); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      sample();
      checks++; if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL iread_strobe k=%0d: got %b want 1", k, mem_read); end
      checks++; if (mem_address !== 28'h10) begin errors++; $display("[TB] FAIL iread_addr k=%0d: got %h want 10", k, mem_address); end
      checks++; if (i_busywait !== (k < 5)) begin errors++; $display("[TB] FAIL iread_busy k=%0d: got %b want %b", k, i_busywait, k < 5); end
      checks++; if (i_readdata !== ((k == 5) ? A5 : '0)) begin errors++; $display("[TB] FAIL iread_data k=%0d: got %h", k, i_readdata); end
      checks++; if (d_busywait !== 1'b0) begin errors++; $display("[TB] FAIL iread_dbusy k=%0d: got %b want 0", k, d_busywait); end
    end
    tick();
    i_read = 0;
    sample();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL iread_end: got %b want 0", mem_read); end
  endtask

  task automatic test_d_write();
    mem_lat = 2;
    tick();
    d_write = 1; d_address = 28'h0000020; d_writedata = WD;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 2) begin d_writedata = ~WD; d_address = 28'h0000021; end
      sample();
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL dwrite_strobe k=%0d: got w=%b r=%b want w=1 r=0", k, mem_write, mem_read); end
      checks++; if (mem_address !== 28'h20) begin errors++; $display("[TB] FAIL dwrite_addr k=%0d: got %h want 20", k, mem_address); end
      checks++; if (mem_writedata !== WD) begin errors++; $display("[TB] FAIL dwrite_data k=%0d: got %h want %h", k, mem_writedata, WD); end
      checks++; if (d_busywait !== (k < 3)) begin errors++; $display("[TB] FAIL dwrite_busy k=%0d: got %b want %b", k, d_busywait, k < 3); end
    end
    tick();
    d_write = 0;
    sample();
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL dwrite_end: got %b want 0", mem_write); end
    checks++; if (mem_arr[8'h20] !== WD) begin errors++; $display("[TB] FAIL dwrite_stored: got %h want %h", mem_arr[8'h20], WD); end
  endtask

  task automatic test_contention();
    do_reset();
    mem_lat = 1;
    tick();
    i_read = 1; i_address = 28'h30; d_read = 1; d_address = 28'h40;
    tick(); sample();
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h40) begin errors++; $display("[TB] FAIL cont_first_grant: got r=%b a=%h want r=1 a=40", mem_read, mem_address); end
    checks++; if (i_busywait !== 1'b1) begin errors++; $display("[TB] FAIL cont_i_wait1: got %b want 1", i_busywait); end
    tick(); sample();
    checks++; if (d_busywait !== 1'b0 || d_readdata !== pat(8'h40)) begin errors++; $display("[TB] FAIL cont_d_done: got b=%b d=%h", d_busywait, d_readdata); end
    checks++; if (i_busywait !== 1'b1 || i_readdata !== '0) begin errors++; $display("[TB] FAIL cont_i_wait2: got b=%b d=%h", i_busywait, i_readdata); end
    tick();
    d_read = 0;
    sample();
    checks++; if (mem_read !== 1'b0 || i_busywait !== 1'b1) begin errors++; $display("[TB] FAIL cont_idle: got r=%b ib=%b want r=0 ib=1", mem_read, i_busywait); end
    tick(); sample();
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h30 || i_busywait !== 1'b1) begin errors++; $display("[TB] FAIL cont_second_grant: got r=%b a=%h ib=%b", mem_read, mem_address, i_busywait); end
    tick(); sample();
    checks++; if (i_busywait !== 1'b0 || i_readdata !== pat(8'h30)) begin errors++; $display("[TB] FAIL cont_i_done: got b=%b d=%h", i_busywait, i_readdata); end
    tick();
    i_read = 0;
  endtask

  task automatic test_back_to_back();
    logic own_d;
    logic [7:0] a;
    mem_lat = 0;
    i_read = 1; i_address = 28'h50; d_read = 1; d_address = 28'h60;
    for (int k = 1; k <= 8; k++) begin
      tick(); sample();
      if (k % 2 == 1) begin
        own_d = (((k - 1) / 2) % 2) == 0;
        a = own_d ? 8'h60 : 8'h50;
        checks++; if (mem_read !== 1'b1 || mem_address !== {20'h0, a}) begin errors++; $display("[TB] FAIL b2b_grant k=%0d: got r=%b a=%h want a=%h", k, mem_read, mem_address, a); end
        checks++; if (d_busywait !== !own_d || i_busywait !== own_d) begin errors++; $display("[TB] FAIL b2b_busy k=%0d: got ib=%b db=%b", k, i_busywait, d_busywait); end
        checks++; if (d_readdata !== (own_d ? pat(8'h60) : '0) || i_readdata !== (own_d ? '0 : pat(8'h50))) begin errors++; $display("[TB] FAIL b2b_data k=%0d: got i=%h d=%h", k, i_readdata, d_readdata); end
      end else begin
        checks++; if (mem_read !== 1'b0 || i_busywait !== 1'b1 || d_busywait !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle k=%0d: got r=%b ib=%b db=%b", k, mem_read, i_busywait, d_busywait); end
      end
    end
    i_read = 0; d_read = 0;
    tick(); sample();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b want 0", mem_read); end
  endtask

  task automatic test_addr_change();
    mem_lat = 3;
    tick();
    i_read = 1; i_address = 28'h10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) i_address = 28'h99;
      sample();
      checks++; if (mem_address !== 28'h10) begin errors++; $display("[TB] FAIL addrchg_addr k=%0d: got %h want 10", k, mem_address); end
      checks++; if (i_busywait !== (k < 4)) begin errors++; $display("[TB] FAIL addrchg_busy k=%0d: got %b want %b", k, i_busywait, k < 4); end
    end
    checks++; if (i_readdata !== A5) begin errors++; $display("[TB] FAIL addrchg_data: got %h want %h", i_readdata, A5); end
    tick();
    i_read = 0;
    sample();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL addrchg_end: got %b want 0", mem_read); end
  endtask

  task automatic test_reset_mid();
    mem_lat = 5;
    tick();
    d_write = 1; d_address = 28'h70; d_writedata = ~WD;
    tick(); sample();
    checks++; if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL rmid_started: got %b want 1", mem_write); end
    tick(); sample();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rmid_strobes: got w=%b r=%b want 0", mem_write, mem_read); end
    checks++; if (mem_address !== '0 || mem_writedata !== '0) begin errors++; $display("[TB] FAIL rmid_fields: got a=%h", mem_address); end
    checks++; if (d_busywait !== 1'b1) begin errors++; $display("[TB] FAIL rmid_dbusy: got %b want 1", d_busywait); end
    d_write = 0;
    @(negedge clk);
    reset = 1'b1;
    mem_lat = 0;
    tick();
    i_read = 1; i_address = 28'h10;
    sample();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle: got %b want 0", mem_read); end
    tick(); sample();
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h10) begin errors++; $display("[TB] FAIL rmid_regrant: got r=%b a=%h", mem_read, mem_address); end
    checks++; if (i_busywait !== 1'b0 || i_readdata !== A5) begin errors++; $display("[TB] FAIL rmid_idone: got b=%b d=%h", i_busywait, i_readdata); end
    tick();
    i_read = 0;
    sample();
  endtask

  // Transaction-level model: owner 0=none 1=I 2=D; grants from free port only.
  task automatic test_random();
    int owner, last;
    logic [AW-1:0] m_addr;
    logic m_write;
    logic [DW-1:0] m_wdata, exp_i, exp_d, exp_done_data;
    logic s_ireq, s_dreq, s_dwrite, s_busy;
    logic [AW-1:0] s_iaddr, s_daddr;
    logic [DW-1:0] s_dwdata;
    logic i_pend, d_pend, i_done, d_done, cpl;
    int ty;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = (i == 16) ? A5 : pat(8'(i));
    owner = 0; last = 1; m_addr = '0; m_write = 0; m_wdata = '0;
    s_ireq = 0; s_dreq = 0; s_dwrite = 0; s_busy = 0; s_iaddr = '0; s_daddr = '0; s_dwdata = '0;
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      i_done = 0; d_done = 0;
      if (owner != 0) begin
        if (!s_busy) begin
          if (owner == 2 && m_write) ref_mem[m_addr[7:0]] = m_wdata;
          if (owner == 1) i_done = 1; else d_done = 1;
          owner = 0;
        end
      end else if (s_ireq || s_dreq) begin
        if (s_ireq && s_dreq) owner = (last == 1) ? 2 : 1;
        else owner = s_ireq ? 1 : 2;
        last = owner;
        if (owner == 1) begin m_addr = s_iaddr; m_write = 0; end
        else begin m_addr = s_daddr; m_write = s_dwrite; m_wdata = s_dwdata; end
        mem_lat = $urandom_range(0, 3);
      end
      if (i_done) i_pend = 0;
      if (d_done) d_pend = 0;
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1; i_address = AW'($urandom);
      end else if (i_pend && $urandom_range(0, 4) == 0) begin
        i_address = AW'($urandom);
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; ty = $urandom_range(0, 2);
        d_address = AW'($urandom);
        d_writedata = {$urandom, $urandom, $urandom, $urandom};
        d_read = (ty != 1); d_write = (ty != 0);
      end else if (d_pend && $urandom_range(0, 4) == 0) begin
        d_address = AW'($urandom);
      end
      i_read = i_pend;
      if (!d_pend) begin d_read = 0; d_write = 0; end
      sample();
      cpl = (owner != 0) && !mem_busywait;
      exp_done_data = m_write ? JUNK : ref_mem[m_addr[7:0]];
      exp_i = (cpl && owner == 1) ? exp_done_data : '0;
      exp_d = (cpl && owner == 2) ? exp_done_data : '0;
      checks++; if (mem_read !== (owner != 0 && !m_write) || mem_write !== (owner != 0 && m_write)) begin errors++; $display("[TB] FAIL rand_strobe c=%0d: got r=%b w=%b owner=%0d", c, mem_read, mem_write, owner); end
      if (owner != 0) begin
        checks++; if (mem_address !== m_addr) begin errors++; $display("[TB] FAIL rand_addr c=%0d: got %h want %h", c, mem_address, m_addr); end
        if (m_write) begin
          checks++; if (mem_writedata !== m_wdata) begin errors++; $display("[TB] FAIL rand_wdata c=%0d: got %h want %h", c, mem_writedata, m_wdata); end
        end
      end
      checks++; if (i_busywait !== (i_read && !(cpl && owner == 1))) begin errors++; $display("[TB] FAIL rand_ibusy c=%0d: got %b", c, i_busywait); end
      checks++; if (d_busywait !== ((d_read || d_write) && !(cpl && owner == 2))) begin errors++; $display("[TB] FAIL rand_dbusy c=%0d: got %b", c, d_busywait); end
      checks++; if (i_readdata !== exp_i) begin errors++; $display("[TB] FAIL rand_idata c=%0d: got %h want %h", c, i_readdata, exp_i); end
      checks++; if (d_readdata !== exp_d) begin errors++; $display("[TB] FAIL rand_ddata c=%0d: got %h want %h", c, d_readdata, exp_d); end
      s_ireq = i_read; s_dreq = d_read || d_write; s_dwrite = d_write;
      s_iaddr = i_address; s_daddr = d_address; s_dwdata = d_writedata; s_busy = mem_busywait;
    end
    i_read = 0; d_read = 0; d_write = 0;
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b0;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
    $display("[TB] starting mem_port_arbiter tests");
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_back_to_back();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
